sync_down_counter: RTL and testbench
====================================

Name: sync_down_counter

Overview:
- Synchronous, loadable down-counter/interval timer. It is the counting-down counterpart of the team's T-flip-flop up-counter chain.
- Counts from a loaded value to zero and flags terminal count (tc).
- Optional auto-reload mode gives a periodic tick.
- Used as a timeout/period generator next to the up-counter datapath. All state changes on the clock; no rippled clocks.

Parameters:
WIDTH, 4, counter and load-value width in bits (max count 2**WIDTH-1)

Ports:
clk  input  1  system clock; all state updates on posedge clk
rst  input  1  reset, asynchronous, active-low (rst==0 resets)
load  input  1  synchronous load strobe; captures load_val
load_val  input  WIDTH  value to load (also stored as reload value)
en  input  1  count enable; decrement allowed only when high
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at terminal count
count  output  WIDTH  current counter value (registered)
busy  output  1  high while state is RUN or HOLD
tc  output  1  registered one-cycle pulse in the cycle count reaches zero or reloads

Behaviour:
- Reset (rst==0, asynchronous, any time including mid-count):
  - count=0, reload_reg=0, tc=0, busy=0, state=IDLE.
  - Outputs change immediately, not at the next edge.
  - Release is sampled at the next posedge.
- States: IDLE, RUN, HOLD. busy is a registered decode of the state (1 in RUN/HOLD).
- Priority per edge: reset > load > terminal-count handling > decrement > hold.
- load=1, any state:
  - reload_reg<=load_val, count<=load_val, tc<=0.
  - load_val==0: next state IDLE; no tc ever generated for it.
  - load_val!=0: next state RUN if en=1, else HOLD.
  - Load overrides a coincident terminal count: no tc that cycle.
- RUN, en=1, count>1: count<=count-1, tc<=0.
- RUN, en=1, count==1 (terminal):
  - tc<=1 for exactly one cycle.
  - auto_reload=1: count<=reload_reg, stay RUN.
  - auto_reload=0: count<=0, next IDLE, so busy=0 in the same cycle tc=1.
- RUN, en=0: count frozen, next HOLD, tc<=0.
- HOLD:
  - en=0: count frozen.
  - en=1: next RUN. The decrement happens in that same edge, so there are no lost cycles; count==1 follows the terminal rules above.
- IDLE: count frozen (0 after one-shot expiry); en ignored; tc=0.
- Latency:
  - Load at edge k gives count=load_val after edge k.
  - First decrement at edge k+1 if en=1.
  - tc asserts after edge k+N for load_val=N with en held high.
- Periodic mode: tc period = reload_reg cycles. reload_reg=1 gives tc every cycle with count staying 1.
- Arithmetic:
  - Unsigned WIDTH-bit.
  - Decrement never applied at count==0, so there is no underflow/wrap to all-ones.
  - load_val=2**WIDTH-1 is legal.
- auto_reload may change at any time; only its value at the terminal edge matters.

Decomposition:
- Shared package: state enum type (IDLE, RUN, HOLD) and the default WIDTH constant, so the up-counter and down-counter benches share them.
- No sub-module is natural: a single flat module with one state register, one count register, one reload register and a registered tc.

Test Plan:
- Reset: hold rst=0 for 1 time unit, then release -> count=0, busy=0, tc=0. Assert rst=0 mid-cycle while count=6 -> count=0, busy=0 immediately, before the next posedge.
- One-shot, WIDTH=4: load 5, en=1, auto_reload=0 -> count 5,4,3,2,1,0 on successive edges. tc=1 only in the cycle count becomes 0, with busy=0 that cycle. count stays 0, tc stays 0 afterwards.
- Periodic: load 3, en=1, auto_reload=1 -> count 3,2,1,3,2,1,3. tc pulses on every return to 3, i.e. every 3 cycles. Clearing auto_reload gives a final 2,1,0 and then IDLE.
- Hold: at count=4 drop en for 2 cycles -> state HOLD, count 4,4, busy=1, tc=0. Raise en -> count 3 on the next edge.
- Reload and load boundaries:
  - load 9 while running at count=2 -> count=9 next edge, no tc.
  - load 9 coincident with count==1 -> count=9, tc=0.
  - load 0 -> IDLE, busy=0, no tc.
- Max value: load 15 (WIDTH=4), en=1 -> tc after exactly 15 cycles. count never wraps to 15 from 0.

Source files
------------

// File: rtl/sync_down_counter_pkg.sv
// Types and defaults shared by the up/down counter blocks and their benches.
package sync_down_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sync_down_counter.sv
// Loadable down-counter / interval timer with one-shot and periodic (auto-reload) modes.
module sync_down_counter
   import sync_down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_e           r_state;
   state_e           w_state_d;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_d;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_d;
   logic             r_tc;
   logic             w_tc_d;
   logic             r_busy;

   always_comb begin
      w_state_d  = r_state;
      w_count_d  = r_count;
      w_reload_d = r_reload;
      w_tc_d     = 1'b0;

      if (load) begin
         w_reload_d = load_val;
         w_count_d  = load_val;
         if (load_val == ZERO) begin
            w_state_d = IDLE;
         end else if (en) begin
            w_state_d = RUN;
         end else begin
            w_state_d = HOLD;
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_state_d = IDLE;
            end
            // HOLD resuming with en=1 decrements on the same edge as RUN does.
            RUN, HOLD: begin
               if (!en) begin
                  w_state_d = HOLD;
               end else if (r_count > ONE) begin
                  w_count_d = r_count - ONE;
                  w_state_d = RUN;
               end else if (r_count == ONE) begin
                  w_tc_d = 1'b1;
                  if (auto_reload) begin
                     w_count_d = r_reload;
                     w_state_d = RUN;
                  end else begin
                     w_count_d = ZERO;
                     w_state_d = IDLE;
                  end
               end else begin
                  w_state_d = IDLE;
               end
            end
            default: begin
               w_state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_count  <= ZERO;
         r_reload <= ZERO;
         r_tc     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_count  <= w_count_d;
         r_reload <= w_reload_d;
         r_tc     <= w_tc_d;
         r_busy   <= (w_state_d != IDLE);
      end
   end

   assign count = r_count;
   assign busy  = r_busy;
   assign tc    = r_tc;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed, table-driven bench for sync_down_counter (WIDTH=4).
module tb_sync_down_counter;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst;
   logic         load;
   logic [W-1:0] load_val;
   logic         en;
   logic         auto_reload;
   logic [W-1:0] count;
   logic         busy;
   logic         tc;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic         load;
      logic [W-1:0] load_val;
      logic         en;
      logic         auto_reload;
      logic [W-1:0] exp_count;
      logic         exp_busy;
      logic         exp_tc;
   } vec_t;

   vec_t vecs[$];

   sync_down_counter #(
      .WIDTH(W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_val   (load_val),
      .en         (en),
      .auto_reload(auto_reload),
      .count      (count),
      .busy       (busy),
      .tc         (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
      end
   endtask

   task automatic check_all(input string name, input int idx, input logic [W-1:0] ec,
                            input logic eb, input logic et);
      check({name, ".count"}, idx, 32'(count), 32'(ec));
      check({name, ".busy"}, idx, 32'(busy), 32'(eb));
      check({name, ".tc"}, idx, 32'(tc), 32'(et));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic ld, input int lv, input logic e, input logic ar,
                      input int ec, input logic eb, input logic et);
      vec_t v;
      v.load        = ld;
      v.load_val    = W'(lv);
      v.en          = e;
      v.auto_reload = ar;
      v.exp_count   = W'(ec);
      v.exp_busy    = eb;
      v.exp_tc      = et;
      vecs.push_back(v);
   endtask

   initial begin
      // One-shot: load 5
      add(1, 5, 1, 0, 5, 1, 0);
      add(0, 0, 1, 0, 4, 1, 0);
      add(0, 0, 1, 0, 3, 1, 0);
      add(0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      // Periodic: load 3, then drop auto_reload
      add(1, 3, 1, 1, 3, 1, 0);
      add(0, 0, 1, 1, 2, 1, 0);
      add(0, 0, 1, 1, 1, 1, 0);
      add(0, 0, 1, 1, 3, 1, 1);
      add(0, 0, 1, 1, 2, 1, 0);
      add(0, 0, 1, 1, 1, 1, 0);
      add(0, 0, 1, 1, 3, 1, 1);
      add(0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 1);
      // Hold at 4 for two cycles, resume, then reload at count 2
      add(1, 6, 1, 0, 6, 1, 0);
      add(0, 0, 1, 0, 5, 1, 0);
      add(0, 0, 1, 0, 4, 1, 0);
      add(0, 0, 0, 0, 4, 1, 0);
      add(0, 0, 0, 0, 4, 1, 0);
      add(0, 0, 1, 0, 3, 1, 0);
      add(0, 0, 1, 0, 2, 1, 0);
      add(1, 9, 1, 0, 9, 1, 0);
      for (int i = 8; i >= 1; i--) add(0, 0, 1, 0, i, 1, 0);
      // Load coincident with count==1 suppresses tc
      add(1, 9, 1, 0, 9, 1, 0);
      // Load 0 goes straight to IDLE
      add(1, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      // reload_reg=1: tc every cycle, count stays 1
      add(1, 1, 1, 1, 1, 1, 0);
      add(0, 0, 1, 1, 1, 1, 1);
      add(0, 0, 1, 1, 1, 1, 1);
      add(0, 0, 1, 0, 0, 0, 1);
      // Load with en=0 enters HOLD; resume counts without a lost cycle
      add(1, 2, 0, 0, 2, 1, 0);
      add(0, 0, 0, 0, 2, 1, 0);
      add(0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 1);
      // Terminal reached directly from HOLD
      add(1, 1, 0, 0, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0);

      rst         = 1'b0;
      load        = 1'b0;
      load_val    = '0;
      en          = 1'b0;
      auto_reload = 1'b0;
      #1;
      check_all("reset", 0, 0, 0, 0);
      rst = 1'b1;
      step();
      check_all("post_reset", 0, 0, 0, 0);

      foreach (vecs[i]) begin
         load        = vecs[i].load;
         load_val    = vecs[i].load_val;
         en          = vecs[i].en;
         auto_reload = vecs[i].auto_reload;
         step();
         check_all("vec", i, vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_tc);
      end

      // Max value: tc exactly 15 cycles after the load, no wrap
      load        = 1'b1;
      load_val    = 4'd15;
      en          = 1'b1;
      auto_reload = 1'b0;
      step();
      check_all("max_load", 0, 15, 1, 0);
      load = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         step();
         check_all("max_run", i, W'(15 - i), (i != 15), (i == 15));
      end
      step();
      check_all("max_after", 0, 0, 0, 0);

      // Asynchronous reset in the middle of a cycle at count 6
      load     = 1'b1;
      load_val = 4'd7;
      step();
      load = 1'b0;
      step();
      check_all("pre_async", 0, 6, 1, 0);
      #2;
      rst = 1'b0;
      #1;
      check_all("async_rst", 0, 0, 0, 0);
      step();
      check_all("async_hold", 0, 0, 0, 0);
      rst = 1'b1;
      step();
      check_all("async_release", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
